// File: rtl/traffic_phase_controller_if.sv
// Signal bundle between the phase controller and its environment: demand inputs in,
// lamp drives and debug state out.
interface traffic_phase_controller_if;
  logic       tick;
  logic       ped_req;
  logic       car_e;
  logic       night;
  logic       rn;
  logic       yn;
  logic       gn;
  logic       re;
  logic       ye;
  logic       ge;
  logic       walk;
  logic       ped_pending;
  logic [2:0] phase;

  modport master (
    output tick, ped_req, car_e, night,
    input  rn, yn, gn, re, ye, ge, walk, ped_pending, phase
  );

  modport slave (
    input  tick, ped_req, car_e, night,
    output rn, yn, gn, re, ye, ge, walk, ped_pending, phase
  );
endinterface

// File: rtl/traffic_phase_controller.sv
// Demand-driven phase sequencer for a two-road intersection: N/S rests in green, E/W and
// pedestrian phases are served on request, with E/W green extensions and a flashing night mode.
module traffic_phase_controller #(
  parameter int unsigned GREEN_TICKS  = 20,
  parameter int unsigned YELLOW_TICKS = 8,
  parameter int unsigned ALLRED_TICKS = 4,
  parameter int unsigned WALK_TICKS   = 16,
  parameter int unsigned EXT_TICKS    = 8,
  parameter int unsigned MAX_EXT      = 2,
  parameter int unsigned TW           = 8
) (
  input logic                      clock,
  input logic                      reset,
  traffic_phase_controller_if.slave bus
);

  typedef enum logic [2:0] {
    StNsGreen  = 3'd0,
    StNsYellow = 3'd1,
    StAllRedA  = 3'd2,
    StEwGreen  = 3'd3,
    StEwYellow = 3'd4,
    StAllRedB  = 3'd5,
    StWalk     = 3'd6,
    StFlash    = 3'd7
  } state_e;

  localparam int unsigned ExtW = (MAX_EXT > 0) ? $clog2(MAX_EXT + 1) : 1;

  localparam logic [TW-1:0]   GreenLoad  = TW'(GREEN_TICKS - 1);
  localparam logic [TW-1:0]   YellowLoad = TW'(YELLOW_TICKS - 1);
  localparam logic [TW-1:0]   AllRedLoad = TW'(ALLRED_TICKS - 1);
  localparam logic [TW-1:0]   WalkLoad   = TW'(WALK_TICKS - 1);
  localparam logic [TW-1:0]   ExtLoad    = TW'(EXT_TICKS - 1);
  localparam logic [ExtW-1:0] MaxExt     = ExtW'(MAX_EXT);

  // Lamp vector order: {rn, yn, gn, re, ye, ge, walk}
  localparam logic [6:0] LampsReset = 7'b001_100_0;

  function automatic logic [TW-1:0] load(state_e s);
    case (s)
      StNsGreen, StEwGreen:   load = GreenLoad;
      StNsYellow, StEwYellow: load = YellowLoad;
      StAllRedA, StAllRedB:   load = AllRedLoad;
      StWalk:                 load = WalkLoad;
      default:                load = '0;
    endcase
  endfunction

  state_e          state_q, state_d;
  logic [TW-1:0]   cnt_q, cnt_d;
  logic [ExtW-1:0] ext_q, ext_d;
  logic            ped_q, ped_d;
  logic            flash_q, flash_d;
  logic [6:0]      lamps_q, lamps_d;
  logic            ped_eff;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ext_d   = ext_q;
    flash_d = flash_q;
    // A button press on the expiring cycle counts as already latched.
    ped_eff = ped_q | (bus.ped_req & (state_q != StWalk));

    if (bus.tick) begin
      if (state_q == StFlash) begin
        flash_d = ~flash_q;
        if (!bus.night) state_d = StAllRedB;
      end else if (cnt_q != '0) begin
        cnt_d = cnt_q - 1'b1;
      end else begin
        case (state_q)
          StNsGreen: begin
            if (bus.night || ped_eff || bus.car_e) state_d = StNsYellow;
          end
          StNsYellow: state_d = StAllRedA;
          StAllRedA: begin
            if (bus.night)   state_d = StFlash;
            else if (ped_eff) state_d = StWalk;
            else             state_d = StEwGreen;
          end
          StEwGreen: begin
            if (bus.car_e && (ext_q < MaxExt)) begin
              cnt_d = ExtLoad;
              ext_d = ext_q + 1'b1;
            end else begin
              state_d = StEwYellow;
            end
          end
          StEwYellow, StWalk: state_d = StAllRedB;
          StAllRedB:          state_d = StNsGreen;
          default:            state_d = state_q;
        endcase
      end
    end

    if (state_d != state_q) begin
      cnt_d   = load(state_d);
      flash_d = 1'b0;
      if (state_d == StEwGreen) ext_d = '0;
    end

    ped_d = ((state_d == StWalk) && (state_q != StWalk)) ? 1'b0 : ped_eff;
  end

  // Lamps are decoded from the next state so they change on the same edge as the phase.
  always_comb begin
    lamps_d = 7'b0;
    case (state_d)
      StNsGreen:            lamps_d = 7'b001_100_0;
      StNsYellow:           lamps_d = 7'b010_100_0;
      StEwGreen:            lamps_d = 7'b100_001_0;
      StEwYellow:           lamps_d = 7'b100_010_0;
      StAllRedA, StAllRedB: lamps_d = 7'b100_100_0;
      StWalk:               lamps_d = 7'b100_100_1;
      StFlash:              lamps_d = {flash_d, 2'b00, flash_d, 3'b000};
      default:              lamps_d = 7'b0;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StNsGreen;
      cnt_q   <= GreenLoad;
      ext_q   <= '0;
      ped_q   <= 1'b0;
      flash_q <= 1'b0;
      lamps_q <= LampsReset;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ext_q   <= ext_d;
      ped_q   <= ped_d;
      flash_q <= flash_d;
      lamps_q <= lamps_d;
    end
  end

  assign bus.rn          = lamps_q[6];
  assign bus.yn          = lamps_q[5];
  assign bus.gn          = lamps_q[4];
  assign bus.re          = lamps_q[3];
  assign bus.ye          = lamps_q[2];
  assign bus.ge          = lamps_q[1];
  assign bus.walk        = lamps_q[0];
  assign bus.ped_pending = ped_q;
  assign bus.phase       = state_q;

endmodule

// File: doc/traffic_phase_controller.md
# traffic_phase_controller

Phase sequencer for the two-road intersection lights. It replaces the fixed light cycle with a demand-driven schedule. Clocked from the divided system clock, it advances on a one-cycle `tick` enable and has its own per-phase duration counter. It serves east/west vehicle requests and latched pedestrian requests, grants vehicle-sensor green extensions, and runs a flashing-red night mode. North/south is the main road and rests in green.

## Interface
- `GREEN_TICKS`, 20: minimum green duration in ticks for either road.
- `YELLOW_TICKS`, 8: yellow duration in ticks.
- `ALLRED_TICKS`, 4: all-red clearance duration in ticks.
- `WALK_TICKS`, 16: pedestrian walk duration in ticks.
- `EXT_TICKS`, 8: length in ticks of one east/west green extension.
- `MAX_EXT`, 2: maximum extensions per east/west green.
- `TW`, 8: duration counter width. Every `*_TICKS` value is in the range 1..2^TW.
- `clock`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `tick`  in  1  phase-time enable, one `clock` cycle wide; if held high, it counts on every cycle.
- `ped_req`  in  1  pedestrian button, active-high, sampled every cycle.
- `car_e`  in  1  east/west vehicle sensor, active-high level.
- `night`  in  1  night-mode request, active-high level.
- `rn`, `yn`, `gn`  out  1 each  north/south red, yellow, green.
- `re`, `ye`, `ge`  out  1 each  east/west red, yellow, green.
- `walk`  out  1  pedestrian walk lamp.
- `ped_pending`  out  1  a latched pedestrian request is waiting.
- `phase`  out  3  current state encoding, for debug.

## Operation
States and encodings:
- NS_GREEN = 0, NS_YELLOW = 1, ALLRED_A = 2, EW_GREEN = 3, EW_YELLOW = 4, ALLRED_B = 5, WALK = 6, FLASH = 7.

Duration counter:
- On entry to a state, the counter loads that state's duration minus 1.
- On a tick with counter ≠ 0, the counter decrements.
- On a tick with counter = 0, the state has expired and the exit rule below is evaluated.
- Each state therefore lasts exactly its duration in ticks, unless held or extended.

Exit rules, evaluated only at expiry:
- NS_GREEN: if `night | ped_pending | car_e`, go to NS_YELLOW. Otherwise hold, with the counter staying at 0. The exit is re-evaluated on every later tick.
- NS_YELLOW: go to ALLRED_A.
- ALLRED_A: priority is `night` > `ped_pending` > otherwise. `night` goes to FLASH, `ped_pending` goes to WALK, otherwise go to EW_GREEN.
- EW_GREEN: if `car_e` is high and ext_count < MAX_EXT, reload EXT_TICKS−1, increment ext_count, and stay. Otherwise go to EW_YELLOW.
- EW_YELLOW: go to ALLRED_B.
- WALK: go to ALLRED_B.
- ALLRED_B: go to NS_GREEN.
- FLASH: the counter is unused. The flash bit toggles on every tick. When `night` is low at a tick, go to ALLRED_B.

Pedestrian and extension bookkeeping:
- `ped_pending` sets on any cycle with `ped_req` high, except while in WALK.
- `ped_pending` clears on the edge that enters WALK. A request during WALK is dropped.
- ext_count clears on entry to EW_GREEN.

Outputs are Moore, decoded from the registered state:
- NS_GREEN: `gn`=1, `re`=1.
- NS_YELLOW: `yn`=1, `re`=1.
- EW_GREEN: `ge`=1, `rn`=1.
- EW_YELLOW: `ye`=1, `rn`=1.
- ALLRED_A, ALLRED_B: `rn`=`re`=1.
- WALK: `rn`=`re`=1 and `walk`=1.
- FLASH: `rn`=`re`=flash bit. All other lamps are 0.
- In every state, at most one lamp per road is lit. Green and yellow are never lit on both roads at once.

## Timing
Reset (`reset`=0) acts immediately and asynchronously, including mid-phase:
- state = NS_GREEN, counter = GREEN_TICKS−1.
- `ped_pending`=0, ext_count=0, flash bit=0.
- Outputs: `gn`=`re`=1, all other outputs 0, `phase`=0.

Latency and sampling:
- A state change takes effect on the rising edge of the expiring tick. Outputs change on that same edge, with no extra latency.
- A `ped_req` pulse of one cycle is latched on the next edge. `ped_pending` is visible 1 cycle after the pulse.
- `car_e` and `night` are sampled only at expiry (FLASH: on every tick). Pulses between those points are ignored.
- A sensor change during tick=0 cycles has no effect.

Simultaneous events: a request arriving in the same cycle as a tick with counter = 0 is honoured on that edge.

## Test plan
Bench parameters: GREEN=4, YELLOW=2, ALLRED=1, WALK=3, EXT=2, MAX_EXT=1, `tick` tied high.

- Reset, then no inputs for 50 cycles -> `phase`=0 throughout; `gn`=`re`=1; all other outputs 0.
- `car_e` held high from reset release -> NS_GREEN 4 cycles, NS_YELLOW 2, ALLRED_A 1, EW_GREEN 6 (one extension only), EW_YELLOW 2, ALLRED_B 1, then NS_GREEN 4 and the sequence repeats.
- Single-cycle `ped_req` at cycle 1 -> `ped_pending`=1 at cycle 2. Sequence is NS_GREEN to cycle 4, NS_YELLOW 2, ALLRED_A 1, then WALK 3 with `walk`=1 and `ped_pending`=0. Then ALLRED_B 1, then NS_GREEN. `ped_req` pulsed during WALK is dropped.
- `ped_req` and `car_e` both high at cycle 0 -> WALK is served before EW_GREEN. EW_GREEN follows after ALLRED_B and the 4-cycle NS_GREEN.
- `night` raised during EW_GREEN -> the EW sequence completes, then NS_GREEN 4, NS_YELLOW, ALLRED_A, FLASH. In FLASH, `rn`/`re` toggle every cycle starting at 0 and all other lamps are 0. Dropping `night` gives ALLRED_B for 1 cycle, then NS_GREEN.
- `reset` pulsed low mid-EW_YELLOW -> outputs go to the reset values asynchronously, before the next edge. After release, NS_GREEN lasts 4 cycles.
